// File: rtl/tag_track_buff_pkg.sv
// ---- tag_track_buff_pkg: shared widths and channel state encoding (rev 1.0) ----
`default_nettype none

package tag_track_buff_pkg;

  // One extra bit beyond the column index so a tag can exceed the last column
  function automatic int calc_tag_w(input int num_col);
    return $clog2(num_col) + 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } ch_state_e;

endpackage

`default_nettype wire

// File: rtl/tag_track_buff_rr_arb.sv
// ---- rr_arb: round-robin arbiter, search starts one past the last grant (rev 1.0) ----
`default_nettype none

module rr_arb
  import tag_track_buff_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_CH);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_nxt    = IDX_W'((int'(idx) + 1) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr <= '0;
    else       ptr <= ptr_nxt;
  end

endmodule

`default_nettype wire

// File: rtl/tag_track_buff.sv
// ---- tag_track_buff: per-channel tag lock with round-robin commit FIFO (rev 1.0) ----
`default_nettype none

module tag_track_buff
  import tag_track_buff_pkg::*;
#(
  parameter  int NUM_COL = 4,
  parameter  int NUM_CH  = 4,
  parameter  int DEPTH   = 4,
  localparam int TAG_W   = calc_tag_w(NUM_COL),
  localparam int CH_W    = idx_w(NUM_CH),
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       flush,
  input  logic [NUM_CH*TAG_W-1:0] tag_in,
  output logic [NUM_CH-1:0]       tag_lock,
  output logic [NUM_CH*TAG_W-1:0] tag_cur,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAG_W-1:0]        out_tag,
  output logic [CH_W-1:0]         out_ch,
  output logic                    fifo_full,
  output logic [AW:0]             fifo_cnt
);

  ch_state_e        state_q [NUM_CH];
  ch_state_e        state_d [NUM_CH];
  logic [TAG_W-1:0] cur_q   [NUM_CH];
  logic [TAG_W-1:0] cur_d   [NUM_CH];

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic              grant_en;
  logic              push;
  logic              pop;
  logic [TAG_W-1:0]  wr_tag;
  logic [CH_W-1:0]   wr_ch;

  logic [TAG_W-1:0]  mem_tag [DEPTH];
  logic [CH_W-1:0]   mem_ch  [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= UNLOCKED;
        cur_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cur_q[i]   <= cur_d[i];
      end
    end
  end

  // A locked channel ignores flushes until its tag has been committed
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cur_d[i]   = cur_q[i];
      if (clear) begin
        state_d[i] = UNLOCKED;
        cur_d[i]   = '0;
      end else if (state_q[i] == UNLOCKED) begin
        if (flush[i] && (tag_in[i*TAG_W +: TAG_W] > cur_q[i])) begin
          cur_d[i]   = tag_in[i*TAG_W +: TAG_W];
          state_d[i] = LOCKED;
        end
      end else if (grant[i]) begin
        state_d[i] = UNLOCKED;
      end
    end
  end

  always_comb begin
    req     = '0;
    tag_cur = '0;
    wr_tag  = '0;
    wr_ch   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req[i]                    = (state_q[i] == LOCKED);
      tag_cur[i*TAG_W +: TAG_W] = cur_q[i];
      if (grant[i]) begin
        wr_tag = cur_q[i];
        wr_ch  = CH_W'(i);
      end
    end
  end

  assign tag_lock = req;

  // A full FIFO still accepts a grant when the head is popped in the same cycle
  assign grant_en = !clear && (!fifo_full || out_ready);

  rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_rr_arb (
    .clk   (clk),
    .rstn  (rstn),
    .en    (grant_en),
    .req   (req),
    .grant (grant)
  );

  assign push = |grant;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_tag[wr_ptr] <= wr_tag;
      mem_ch[wr_ptr]  <= wr_ch;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign fifo_cnt  = cnt;
  assign out_valid = (cnt != '0);
  assign fifo_full = (cnt == (AW+1)'(DEPTH));
  assign out_tag   = mem_tag[rd_ptr];
  assign out_ch    = mem_ch[rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_tag_track_buff.sv
// ---- tb_tag_track_buff: directed vector table plus hand sequences for tag_track_buff (rev 1.0) ----
`default_nettype none

module tb_tag_track_buff;

  logic        clk;
  logic        rstn;
  logic        clear;
  logic [3:0]  flush;
  logic [11:0] tag_in;
  logic [3:0]  tag_lock;
  logic [11:0] tag_cur;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_tag;
  logic [1:0]  out_ch;
  logic        fifo_full;
  logic [2:0]  fifo_cnt;

  int total = 0;
  int bad   = 0;

  tag_track_buff #(
    .NUM_COL (4),
    .NUM_CH  (4),
    .DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .flush     (flush),
    .tag_in    (tag_in),
    .tag_lock  (tag_lock),
    .tag_cur   (tag_cur),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_ch    (out_ch),
    .fifo_full (fifo_full),
    .fifo_cnt  (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rstn;
    logic        clr;
    logic [3:0]  flush;
    logic [11:0] tag_in;
    logic        rdy;
    logic [3:0]  lock;
    logic [11:0] cur;
    logic        vld;
    logic [2:0]  otag;
    logic [1:0]  och;
    logic [2:0]  cnt;
    logic        full;
  } vec_t;

  vec_t vt[$];

  function automatic logic [11:0] pk(input int t0, input int t1, input int t2, input int t3);
    return {3'(t3), 3'(t2), 3'(t1), 3'(t0)};
  endfunction

  function automatic vec_t mk(input string n, input logic rs, input logic cl, input logic [3:0] fl,
                              input logic [11:0] ti, input logic rd, input logic [3:0] lk,
                              input logic [11:0] cu, input logic vl, input int ot, input int oc,
                              input int cn, input logic fu);
    vec_t v;
    v.name = n; v.rstn = rs; v.clr = cl; v.flush = fl; v.tag_in = ti; v.rdy = rd;
    v.lock = lk; v.cur = cu; v.vld = vl; v.otag = 3'(ot); v.och = 2'(oc); v.cnt = 3'(cn); v.full = fu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; clear = 1'b0; flush = '0; tag_in = '0; out_ready = 1'b0;

    // name, rstn, clr, flush, tag_in, rdy | lock, cur, vld, otag, och, cnt, full
    vt.push_back(mk("rst",         0,0,4'b0000,pk(0,0,0,0),0, 4'b0000,pk(0,0,0,0),0,0,0,0,0));
    vt.push_back(mk("lock0",       1,0,4'b0001,pk(3,0,0,0),0, 4'b0001,pk(3,0,0,0),0,0,0,0,0));
    vt.push_back(mk("commit0",     1,0,4'b0000,pk(0,0,0,0),0, 4'b0000,pk(3,0,0,0),1,3,0,1,0));
    vt.push_back(mk("pop0",        1,0,4'b0000,pk(0,0,0,0),1, 4'b0000,pk(3,0,0,0),0,0,0,0,0));
    vt.push_back(mk("lock1_5",     1,0,4'b0010,pk(0,5,0,0),1, 4'b0010,pk(3,5,0,0),0,0,0,0,0));
    vt.push_back(mk("commit1_5",   1,0,4'b0000,pk(0,0,0,0),1, 4'b0000,pk(3,5,0,0),1,5,1,1,0));
    vt.push_back(mk("flush_lt",    1,0,4'b0010,pk(0,4,0,0),1, 4'b0000,pk(3,5,0,0),0,0,0,0,0));
    vt.push_back(mk("flush_eq",    1,0,4'b0010,pk(0,5,0,0),1, 4'b0000,pk(3,5,0,0),0,0,0,0,0));
    vt.push_back(mk("flush_gt",    1,0,4'b0010,pk(0,6,0,0),1, 4'b0010,pk(3,6,0,0),0,0,0,0,0));
    vt.push_back(mk("commit1_6",   1,0,4'b0000,pk(0,0,0,0),0, 4'b0000,pk(3,6,0,0),1,6,1,1,0));
    vt.push_back(mk("drain1",      1,0,4'b0000,pk(0,0,0,0),1, 4'b0000,pk(3,6,0,0),0,0,0,0,0));
    vt.push_back(mk("rst2",        0,0,4'b0000,pk(0,0,0,0),0, 4'b0000,pk(0,0,0,0),0,0,0,0,0));
    vt.push_back(mk("lock_all",    1,0,4'b1111,pk(1,2,3,4),0, 4'b1111,pk(1,2,3,4),0,0,0,0,0));
    vt.push_back(mk("fill1",       1,0,4'b0000,pk(0,0,0,0),0, 4'b1110,pk(1,2,3,4),1,1,0,1,0));
    vt.push_back(mk("fill2",       1,0,4'b0000,pk(0,0,0,0),0, 4'b1100,pk(1,2,3,4),1,1,0,2,0));
    vt.push_back(mk("fill3",       1,0,4'b0000,pk(0,0,0,0),0, 4'b1000,pk(1,2,3,4),1,1,0,3,0));
    vt.push_back(mk("fill4",       1,0,4'b0000,pk(0,0,0,0),0, 4'b0000,pk(1,2,3,4),1,1,0,4,1));
    vt.push_back(mk("lock_full",   1,0,4'b0001,pk(7,0,0,0),0, 4'b0001,pk(7,2,3,4),1,1,0,4,1));
    vt.push_back(mk("blocked",     1,0,4'b0000,pk(0,0,0,0),0, 4'b0001,pk(7,2,3,4),1,1,0,4,1));
    vt.push_back(mk("pushpop0",    1,0,4'b0000,pk(0,0,0,0),1, 4'b0000,pk(7,2,3,4),1,2,1,4,1));
    vt.push_back(mk("lock2",       1,0,4'b0100,pk(0,0,5,0),0, 4'b0100,pk(7,2,5,4),1,2,1,4,1));
    vt.push_back(mk("pushpop2",    1,0,4'b0000,pk(0,0,0,0),1, 4'b0000,pk(7,2,5,4),1,3,2,4,1));
    vt.push_back(mk("clear_flush", 1,1,4'b1000,pk(0,0,0,2),0, 4'b0000,pk(0,0,0,0),1,3,2,4,1));
    vt.push_back(mk("drain_a",     1,0,4'b0000,pk(0,0,0,0),1, 4'b0000,pk(0,0,0,0),1,4,3,3,0));
    vt.push_back(mk("drain_b",     1,0,4'b0000,pk(0,0,0,0),1, 4'b0000,pk(0,0,0,0),1,7,0,2,0));
    vt.push_back(mk("hold",        1,0,4'b0000,pk(0,0,0,0),0, 4'b0000,pk(0,0,0,0),1,7,0,2,0));
    vt.push_back(mk("lock_pre_clr",1,0,4'b0010,pk(0,1,0,0),0, 4'b0010,pk(0,1,0,0),1,7,0,2,0));
    vt.push_back(mk("clear_blocks",1,1,4'b0000,pk(0,0,0,0),0, 4'b0000,pk(0,0,0,0),1,7,0,2,0));
    vt.push_back(mk("lock0_6",     1,0,4'b0001,pk(6,0,0,0),0, 4'b0001,pk(6,0,0,0),1,7,0,2,0));
    vt.push_back(mk("commit0_6",   1,0,4'b0100,pk(0,0,1,0),0, 4'b0100,pk(6,0,1,0),1,7,0,3,0));
    vt.push_back(mk("pushpop_c",   1,0,4'b0000,pk(0,0,0,0),1, 4'b0000,pk(6,0,1,0),1,5,2,3,0));
    vt.push_back(mk("pend_lock",   1,0,4'b0010,pk(0,3,0,0),0, 4'b0010,pk(6,3,1,0),1,5,2,3,0));

    foreach (vt[i]) begin
      rstn      = vt[i].rstn;
      clear     = vt[i].clr;
      flush     = vt[i].flush;
      tag_in    = vt[i].tag_in;
      out_ready = vt[i].rdy;
      step();
      chk({vt[i].name, "_lock"}, 32'(tag_lock),  32'(vt[i].lock));
      chk({vt[i].name, "_cur"},  32'(tag_cur),   32'(vt[i].cur));
      chk({vt[i].name, "_vld"},  32'(out_valid), 32'(vt[i].vld));
      chk({vt[i].name, "_cnt"},  32'(fifo_cnt),  32'(vt[i].cnt));
      chk({vt[i].name, "_full"}, 32'(fifo_full), 32'(vt[i].full));
      if (vt[i].vld) begin
        chk({vt[i].name, "_otag"}, 32'(out_tag), 32'(vt[i].otag));
        chk({vt[i].name, "_och"},  32'(out_ch),  32'(vt[i].och));
      end
    end

    // Asynchronous reset mid-drain: outputs must drop before any clock edge
    flush = '0; tag_in = '0; out_ready = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    chk("async_vld",  32'(out_valid), 32'd0);
    chk("async_cnt",  32'(fifo_cnt),  32'd0);
    chk("async_lock", 32'(tag_lock),  32'd0);
    chk("async_cur",  32'(tag_cur),   32'd0);
    chk("async_full", 32'(fifo_full), 32'd0);
    step();
    chk("rst_hold_vld", 32'(out_valid), 32'd0);

    // After release: no stale entries, and the arbiter restarts its search at channel 0
    rstn   = 1'b1;
    flush  = 4'b1010;
    tag_in = pk(0, 2, 0, 2);
    step();
    chk("post_lock",  32'(tag_lock),  32'hA);
    chk("post_vld",   32'(out_valid), 32'd0);
    flush  = '0;
    tag_in = '0;
    step();
    chk("rr_first_vld",  32'(out_valid), 32'd1);
    chk("rr_first_ch",   32'(out_ch),    32'd1);
    chk("rr_first_tag",  32'(out_tag),   32'd2);
    chk("rr_first_lock", 32'(tag_lock),  32'h8);
    step();
    chk("rr_second_cnt",  32'(fifo_cnt), 32'd2);
    chk("rr_second_lock", 32'(tag_lock), 32'h0);
    chk("rr_head_stable", 32'(out_ch),   32'd1);
    out_ready = 1'b1;
    step();
    chk("rr_pop_cnt", 32'(fifo_cnt), 32'd1);
    chk("rr_pop_ch",  32'(out_ch),   32'd3);
    chk("rr_pop_tag", 32'(out_tag),  32'd2);
    step();
    chk("rr_empty_vld", 32'(out_valid), 32'd0);
    chk("rr_empty_cnt", 32'(fifo_cnt),  32'd0);
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tag_track_buff.md
TAG_TRACK_BUFF -- requirements
Module: tag_track_buff

Interface
REQ-001 Parameter NUM_COL, default 4: number of columns; tag width TAG_W = clog2(NUM_COL)+1, with one extension bit.
REQ-002 Parameter NUM_CH, default 4: number of independent tag channels; minimum 1.
REQ-003 Parameter DEPTH, default 4: depth of the committed-tag FIFO; power of two, minimum 2.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rstn  in  1  reset, asynchronous assertion, active-low.
REQ-006 clear  in  1  synchronous layer restart: zeroes all channel tags and locks.
REQ-007 flush  in  NUM_CH  per-channel flush strobe.
REQ-008 tag_in  in  NUM_CH*TAG_W  per-channel candidate tag; channel i occupies bits [i*TAG_W +: TAG_W].
REQ-009 tag_lock  out  NUM_CH  per-channel lock state; 1 = captured tag is awaiting commit.
REQ-010 tag_cur  out  NUM_CH*TAG_W  per-channel current held tag.
REQ-011 out_valid  out  1  FIFO head is valid.
REQ-012 out_ready  in  1  consumer accepts the head.
REQ-013 out_tag  out  TAG_W  tag at the FIFO head.
REQ-014 out_ch  out  clog2(NUM_CH) (min 1)  source channel of the head entry.
REQ-015 fifo_full  out  1  FIFO holds DEPTH entries.
REQ-016 fifo_cnt  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Each channel SHALL have two states: UNLOCKED and LOCKED; both SHALL be fully registered with no combinational feedback.
REQ-018 In UNLOCKED, if flush[i]=1 and tag_in[i] > tag_cur[i] (unsigned, TAG_W bits), the channel SHALL load tag_in[i] into tag_cur[i] at the edge and go to LOCKED.
REQ-019 In UNLOCKED, flush[i] with tag_in[i] <= tag_cur[i] SHALL be ignored; in LOCKED, every flush[i] SHALL be ignored and tag_cur[i] held.
REQ-020 A round-robin arbiter SHALL grant one LOCKED channel per cycle; the search SHALL start at the index after the last grant, and the first search after reset SHALL start at index 0.
REQ-021 A grant SHALL occur only when FIFO space exists, i.e. fifo_cnt < DEPTH, or fifo_cnt = DEPTH and a pop occurs in the same cycle.
REQ-022 On a grant, the channel's {ch, tag_cur} SHALL be written to the FIFO, and the channel SHALL return to UNLOCKED at the same edge; tag_cur SHALL retain its value.
REQ-023 Latency, with no contention and an empty FIFO: flush sampled at edge n -> tag_lock=1 after edge n -> grant and write at edge n+1 -> out_valid=1 and tag_lock=0 after edge n+1.
REQ-024 A pop SHALL occur when out_valid & out_ready; out_tag and out_ch SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 A simultaneous push and pop SHALL leave fifo_cnt unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-026 out_valid SHALL equal (fifo_cnt != 0), and fifo_full SHALL equal (fifo_cnt == DEPTH).
REQ-027 clear=1 SHALL zero every tag_cur, force every channel to UNLOCKED, and block any grant in that cycle; clear SHALL take priority over a flush in the same cycle; FIFO contents and the arbiter pointer SHALL be preserved.
REQ-028 A channel with tag_cur = 2^TAG_W - 1 SHALL never be relocked until a clear, because no greater tag exists.

Reset
REQ-029 When rstn=0, asynchronously: all tag_cur=0, tag_lock=0, FIFO pointers=0, fifo_cnt=0, out_valid=0, fifo_full=0, arbiter pointer=0.
REQ-030 A reset during any operation SHALL discard pending locks and FIFO entries, and no stale out_valid SHALL appear after release.

Structure
REQ-031 A shared package SHALL hold the TAG_W derivation, a channel-index width function, and the channel state encoding (UNLOCKED=0, LOCKED=1).
REQ-032 The round-robin arbiter SHALL be a separate sub-module named rr_arb, parameterised by NUM_CH, with request vector in, one-hot grant out, and a grant-enable input.
REQ-033 The FIFO SHALL be inline register-array logic with no vendor macro.

Verification (NUM_COL=4, TAG_W=3, NUM_CH=4, DEPTH=4)
REQ-034 Reset, then flush[0]=1 with tag_in ch0=3 -> tag_lock[0]=1 one cycle later; out_valid=1 with out_tag=3 and out_ch=0 the next cycle; tag_lock[0]=0.
REQ-035 Channel 1 holds tag_cur=5; flush with tag 4, then 5 -> no lock and tag_cur stays 5; flush with tag 6 -> lock, commit 6.
REQ-036 All four channels flushed in the same cycle with tags 1,2,3,4 and out_ready=0 -> 4 entries in order ch0..ch3, fifo_full=1; a later flush on ch0 with tag 7 stays locked until one pop, then commits.
REQ-037 FIFO full with out_ready=1 and a ch2 lock pending -> push and pop in the same cycle, fifo_cnt holds at 4.
REQ-038 clear in the same cycle as flush[3] with tag 2 -> tag_cur[3]=0, no lock; the existing FIFO entries still drain intact.
REQ-039 rstn pulsed low mid-drain with 3 entries queued -> out_valid=0 immediately, fifo_cnt=0, all tag_lock=0.
